// File: rtl/wb_regfile_pkg.sv
// Shared widths and encodings for the writeback register file and control decoder.
// The optional macro RF_WB_BYPASS_EN lives in wb_regfile.sv.
package wb_regfile_pkg;

    localparam int XLEN        = 32;
    localparam int RFIDX_WIDTH = 5;
    localparam int RF_NREGS    = 1 << RFIDX_WIDTH;

    localparam logic [RFIDX_WIDTH-1:0] RF_ZERO_IDX = '0;

    typedef enum logic {
        WBSEL_ALU = 1'b0,
        WBSEL_MEM = 1'b1
    } wbsel_e;

    // A write only retires when enabled and not aimed at the hardwired-zero entry.
    function automatic logic rf_commit(input logic we, input logic [RFIDX_WIDTH-1:0] rd);
        return we && (rd != RF_ZERO_IDX);
    endfunction

endpackage

// File: rtl/wb_regfile_wb_sel.sv
// Writeback value select: load data or ALU result. Pure combinational so the
// forwarding unit can reuse it.
module wb_sel
    import wb_regfile_pkg::*;
(
    input  logic            i_sel,
    input  logic [XLEN-1:0] i_mem_data,
    input  logic [XLEN-1:0] i_alu_data,
    output logic [XLEN-1:0] o_data
);

    assign o_data = (wbsel_e'(i_sel) == WBSEL_MEM) ? i_mem_data : i_alu_data;

endmodule

// File: rtl/wb_regfile.sv
// Integer register file with writeback commit, two combinational read ports and a
// retired-write counter. Define RF_WB_BYPASS_EN for write-first same-cycle forwarding.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int NREGS     = RF_NREGS,
    parameter int CNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wb_reg_write,
    input  logic                   wb_memtoreg,
    input  logic [XLEN-1:0]        m_data,
    input  logic [XLEN-1:0]        ex_result,
    input  logic [RFIDX_WIDTH-1:0] rd_index,
    input  logic [RFIDX_WIDTH-1:0] rs1_index,
    input  logic [RFIDX_WIDTH-1:0] rs2_index,
    output logic [XLEN-1:0]        rs1_data,
    output logic [XLEN-1:0]        rs2_data,
    output logic [XLEN-1:0]        wb_data,
    output logic [CNT_WIDTH-1:0]   wb_count
);

    // Entry 0 has no storage; reads of it are forced to zero below.
    logic [XLEN-1:0]                  r_regs [1:NREGS-1];
    logic [CNT_WIDTH-1:0]             r_wb_count;
    logic                             w_commit;
    logic [1:0][RFIDX_WIDTH-1:0]      w_rs_idx;

    wb_sel u_wb_sel (
        .i_sel      (wb_memtoreg),
        .i_mem_data (m_data),
        .i_alu_data (ex_result),
        .o_data     (wb_data)
    );

    assign w_commit = rf_commit(wb_reg_write, rd_index);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
            r_wb_count <= '0;
        end else if (w_commit) begin
            r_regs[rd_index] <= wb_data;
            r_wb_count       <= r_wb_count + 1'b1;
        end
    end

    assign wb_count = r_wb_count;
    assign w_rs_idx = {rs2_index, rs1_index};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic [XLEN-1:0] w_data;
            always_comb begin
                w_data = '0;
                if (w_rs_idx[gi] != RF_ZERO_IDX) begin
                    w_data = r_regs[w_rs_idx[gi]];
                end
`ifdef RF_WB_BYPASS_EN
                // Write-first: the committing value wins over the stale array entry.
                if (!rst && w_commit && (w_rs_idx[gi] == rd_index)) begin
                    w_data = wb_data;
                end
`endif
            end
        end
    endgenerate

    assign rs1_data = g_rd[0].w_data;
    assign rs2_data = g_rd[1].w_data;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile (CNT_WIDTH=4 build so counter wrap is reachable).
// Honours RF_WB_BYPASS_EN in its reference model when the macro is defined.
module tb_wb_regfile;

    logic        clk;
    logic        rst;
    logic        wb_reg_write;
    logic        wb_memtoreg;
    logic [31:0] m_data;
    logic [31:0] ex_result;
    logic [4:0]  rd_index;
    logic [4:0]  rs1_index;
    logic [4:0]  rs2_index;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] wb_data;
    logic [3:0]  wb_count;

    int          checks;
    int          errors;

    logic [31:0] model_rf [32];
    int unsigned model_cnt;

    wb_regfile #(.CNT_WIDTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .wb_reg_write (wb_reg_write),
        .wb_memtoreg  (wb_memtoreg),
        .m_data       (m_data),
        .ex_result    (ex_result),
        .rd_index     (rd_index),
        .rs1_index    (rs1_index),
        .rs2_index    (rs2_index),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .wb_data      (wb_data),
        .wb_count     (wb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_read(input logic [4:0] idx, input logic we,
                                             input logic [4:0] rd, input logic r,
                                             input logic [31:0] wbv);
        if (idx == 5'd0) return 32'h0;
`ifdef RF_WB_BYPASS_EN
        if (!r && we && rd != 5'd0 && rd == idx) return wbv;
`endif
        return model_rf[idx];
    endfunction

    // One clock cycle: drive, check combinational outputs on the falling edge,
    // then advance the reference model across the rising edge.
    task automatic cyc(input logic we, input logic msel, input logic [31:0] m,
                       input logic [31:0] ex, input logic [4:0] rd, input logic [4:0] a,
                       input logic [4:0] b, input logic r, input string tag);
        logic [31:0] exp_wb;
        logic [31:0] exp1;
        logic [31:0] exp2;
        logic [3:0]  exp_cnt;
        rst = r; wb_reg_write = we; wb_memtoreg = msel; m_data = m; ex_result = ex;
        rd_index = rd; rs1_index = a; rs2_index = b;
        @(negedge clk);
        exp_wb  = msel ? m : ex;
        exp1    = ref_read(a, we, rd, r, exp_wb);
        exp2    = ref_read(b, we, rd, r, exp_wb);
        exp_cnt = 4'(model_cnt);
        checks++;
        assert (wb_data === exp_wb) else begin
            errors++;
            $error("FAIL %s wb_data got=%h exp=%h", tag, wb_data, exp_wb);
        end
        checks++;
        assert (rs1_data === exp1) else begin
            errors++;
            $error("FAIL %s rs1_data[%0d] got=%h exp=%h", tag, a, rs1_data, exp1);
        end
        checks++;
        assert (rs2_data === exp2) else begin
            errors++;
            $error("FAIL %s rs2_data[%0d] got=%h exp=%h", tag, b, rs2_data, exp2);
        end
        checks++;
        assert (wb_count === exp_cnt) else begin
            errors++;
            $error("FAIL %s wb_count got=%0d exp=%0d", tag, wb_count, exp_cnt);
        end
        $display("%s rst=%0d we=%0d rd=%0d wb=%h rs1[%0d]=%h rs2[%0d]=%h cnt=%0d",
                 tag, r, we, rd, wb_data, a, rs1_data, b, rs2_data, wb_count);
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 32; i++) model_rf[i] = 32'h0;
            model_cnt = 0;
        end else if (we && rd != 5'd0) begin
            model_rf[rd] = exp_wb;
            model_cnt    = (model_cnt + 1) % 16;
        end
        #1;
    endtask

    task automatic rnd(input logic r, input string tag);
        cyc(1'($urandom), 1'($urandom), $urandom, $urandom, 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), r, tag);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        model_cnt = 0;
        for (int i = 0; i < 32; i++) model_rf[i] = 32'h0;
        rst = 1'b1; wb_reg_write = 1'b0; wb_memtoreg = 1'b0;
        m_data = '0; ex_result = '0; rd_index = '0; rs1_index = '0; rs2_index = '0;
        repeat (2) @(posedge clk);
        #1;

        // Random traffic, then a two-cycle reset with writes still presented.
        for (int i = 0; i < 24; i++) rnd(1'b0, "rand_pre");
        rnd(1'b1, "reset_wr0");
        rnd(1'b1, "reset_wr1");
        for (int i = 0; i < 32; i++)
            cyc(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'(i), 5'(31 - i), 1'b0, "reset_sweep");

        // ALU write to x5, load write to x31.
        cyc(1'b1, 1'b0, 32'hCAFE_0000, 32'h1234_5678, 5'd5, 5'd0, 5'd0, 1'b0, "alu_wr");
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd5, 1'b0, "alu_rd");
        cyc(1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0, 5'd31, 5'd0, 5'd0, 1'b0, "load_wr");
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd31, 5'd5, 1'b0, "load_rd");

        // x0 is hardwired and does not count.
        cyc(1'b1, 1'b0, 32'h0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0, 1'b0, "x0_wr");
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, "x0_rd");

        // Same-cycle read of the register being written.
        cyc(1'b1, 1'b0, 32'h0, 32'h0000_0001, 5'd7, 5'd0, 5'd0, 1'b0, "x7_pre");
        cyc(1'b1, 1'b1, 32'hA5A5_A5A5, 32'h0, 5'd7, 5'd7, 5'd7, 1'b0, "x7_same");
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd7, 1'b0, "x7_next");

        // Reset coinciding with a write to x3.
        cyc(1'b1, 1'b0, 32'h0, 32'h3333_3333, 5'd3, 5'd0, 5'd0, 1'b0, "x3_pre");
        cyc(1'b1, 1'b0, 32'h0, 32'h7777_7777, 5'd3, 5'd3, 5'd3, 1'b1, "x3_rst");
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd7, 1'b0, "x3_after");

        // Drive the counter to its maximum, then wrap it.
        for (int i = 0; i < 20 && model_cnt != 15; i++)
            cyc(1'b1, 1'b0, 32'h0, 32'(i), 5'(1 + i % 30), 5'd1, 5'd2, 1'b0, "cnt_fill");
        cyc(1'b1, 1'b1, 32'hFEED_F00D, 32'h0, 5'd9, 5'd9, 5'd0, 1'b0, "cnt_wrap");
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd9, 5'd1, 1'b0, "cnt_after");

        // Long random run with occasional resets.
        for (int i = 0; i < 200; i++) rnd(($urandom_range(0, 19) == 0), "rand_post");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
